// File: rtl/vrased_reset_ctrl.sv
// -----------------------------------------------------------------------------
// vrased_reset_ctrl
//
// Reset sequencer and violation logger placed after the VRASED hardware
// monitor. It takes the six sub-monitor violation flags and turns any
// violation into a fixed-length system reset pulse. It then waits for the
// CPU to fetch from the reset handler before re-arming. For post-reset
// diagnostics it also records:
//   - the cause vector,
//   - the PC at which the violation was first seen,
//   - a saturating count of violation events.
//
// Parameters
//   HOLD_CYCLES    length of the sys_rst pulse in clk cycles (1..65535)
//   CNT_WIDTH      width of the violation event counter
//   RESET_HANDLER  PC value that marks re-entry into the reset handler
//
// Ports
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous, active-high reset
//   pc         in   current CPU program counter
//   viol       in   violation flags: [0] X_stack, [1] AC, [2] atomicity,
//                   [3] dma_AC, [4] dma_detect, [5] dma_X_stack
//   log_clr    in   single-cycle pulse that clears the diagnostic log
//   sys_rst    out  registered system reset request (drives the MCU PUC)
//   cause      out  captured violation vector
//   cause_pc   out  PC sampled on the cycle the violation was first seen
//   viol_cnt   out  saturating number of violation events
//   log_valid  out  high whenever viol_cnt is non-zero
// -----------------------------------------------------------------------------
module vrased_reset_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          pc,
  input  logic [5:0]           viol,
  input  logic                 log_clr,
  output logic                 sys_rst,
  output logic [5:0]           cause,
  output logic [15:0]          cause_pc,
  output logic [CNT_WIDTH-1:0] viol_cnt,
  output logic                 log_valid
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
    WAIT_HANDLER = 2'd2
  } state_t;

  // The hold counter is loaded with HOLD_CYCLES-1. Together with the entry
  // cycle, this gives exactly HOLD_CYCLES cycles of sys_rst.
  localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

  state_t      state;
  logic [15:0] hold_cnt;

  logic any_viol;
  logic viol_event;
  logic in_hold;

  // Saturating increment of the event counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (&v) r = v;
    else    r = v + CNT_WIDTH'(1);
    return r;
  endfunction

  // A violation seen outside HOLD starts a new event. While in HOLD,
  // violations only widen the cause vector and may extend the pulse.
  always_comb begin
    any_viol   = |viol;
    in_hold    = (state == HOLD);
    viol_event = any_viol && !in_hold;
  end

  // ---- reset sequencer FSM --------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sys_rst  <= 1'b0;
      hold_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_viol) begin
            state    <= HOLD;
            sys_rst  <= 1'b1;
            hold_cnt <= HOLD_RELOAD;
          end
        end

        HOLD: begin
          if (hold_cnt != 16'd0) begin
            hold_cnt <= hold_cnt - 16'd1;
          end else if (any_viol) begin
            // A violation still present on the last cycle stretches the pulse.
            hold_cnt <= HOLD_RELOAD;
          end else begin
            state   <= WAIT_HANDLER;
            sys_rst <= 1'b0;
          end
        end

        WAIT_HANDLER: begin
          // A new violation outranks reaching the handler.
          if (any_viol) begin
            state    <= HOLD;
            sys_rst  <= 1'b1;
            hold_cnt <= HOLD_RELOAD;
          end else if (pc == RESET_HANDLER) begin
            state <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          sys_rst  <= 1'b0;
          hold_cnt <= 16'd0;
        end
      endcase
    end
  end

  // ---- diagnostic log -------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cause    <= 6'd0;
      cause_pc <= 16'd0;
      viol_cnt <= '0;
    end else if (viol_event) begin
      // An event capture wins over a coincident log_clr.
      // The counter then restarts at 1.
      cause    <= viol;
      cause_pc <= pc;
      viol_cnt <= log_clr ? CNT_WIDTH'(1) : sat_inc(viol_cnt);
    end else if (log_clr) begin
      // Outside HOLD, viol is zero here, because anything else would be an
      // event. Within HOLD, the accumulating cause restarts from viol.
      cause    <= in_hold ? viol : 6'd0;
      cause_pc <= 16'd0;
      viol_cnt <= '0;
    end else if (in_hold) begin
      cause <= cause | viol;
    end
  end

  assign log_valid = |viol_cnt;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
module tb_vrased_reset_ctrl;

  localparam int H = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        log_clr;
  logic [15:0] pc;
  logic [5:0]  viol;

  logic        sys_rst;
  logic [5:0]  cause;
  logic [15:0] cause_pc;
  logic [7:0]  viol_cnt;
  logic        log_valid;

  // Second instance with the minimum pulse length.
  logic        sys_rst_h1;
  logic [5:0]  cause_h1;
  logic [15:0] cause_pc_h1;
  logic [7:0]  viol_cnt_h1;
  logic        log_valid_h1;

  vrased_reset_ctrl #(.HOLD_CYCLES(H), .CNT_WIDTH(8), .RESET_HANDLER(16'h0000)) dut (
    .clk(clk), .reset(reset), .pc(pc), .viol(viol), .log_clr(log_clr),
    .sys_rst(sys_rst), .cause(cause), .cause_pc(cause_pc),
    .viol_cnt(viol_cnt), .log_valid(log_valid)
  );

  vrased_reset_ctrl #(.HOLD_CYCLES(1), .CNT_WIDTH(8), .RESET_HANDLER(16'h0000)) dut_h1 (
    .clk(clk), .reset(reset), .pc(pc), .viol(viol), .log_clr(log_clr),
    .sys_rst(sys_rst_h1), .cause(cause_h1), .cause_pc(cause_pc_h1),
    .viol_cnt(viol_cnt_h1), .log_valid(log_valid_h1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the pulse is tracked as the absolute index of the last edge
  // after which sys_rst must read high.
  int          mk     = 0;   // edges seen so far
  int          mpu    = -1;  // sys_rst high after edges up to and including mpu
  logic [5:0]  mcause = '0;
  logic [15:0] mpc    = '0;
  int          mcnt   = 0;
  bit          mvalid = 1'b0;

  always @(posedge clk) begin : model
    bit in_hold;
    bit ev;
    mk++;
    if (reset) begin
      mpu    = mk - 1;
      mcause = '0;
      mpc    = '0;
      mcnt   = 0;
    end else begin
      in_hold = (mk - 1 <= mpu);
      ev      = !in_hold && (viol != 6'd0);
      if (in_hold && (mk == mpu + 1) && (viol != 6'd0)) mpu = mk + H - 1;
      else if (ev)                                       mpu = mk + H - 1;
      if (ev) begin
        mcause = viol;
        mpc    = pc;
        mcnt   = log_clr ? 1 : ((mcnt < 255) ? mcnt + 1 : 255);
      end else if (log_clr) begin
        mcause = in_hold ? viol : 6'd0;
        mpc    = '0;
        mcnt   = 0;
      end else if (in_hold) begin
        mcause = mcause | viol;
      end
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_sys_rst",   32'(sys_rst),   32'(mk <= mpu));
      chk("m_cause",     32'(cause),     32'(mcause));
      chk("m_cause_pc",  32'(cause_pc),  32'(mpc));
      chk("m_viol_cnt",  32'(viol_cnt),  32'(mcnt));
      chk("m_log_valid", 32'(log_valid), 32'(mcnt != 0));
    end
  end

  task automatic step(input logic r, input logic [5:0] v, input logic [15:0] p, input logic c);
    reset   = r;
    viol    = v;
    pc      = p;
    log_clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sys_rst"},   32'(sys_rst),   32'd0);
    chk({tag, "_cause"},     32'(cause),     32'd0);
    chk({tag, "_cause_pc"},  32'(cause_pc),  32'd0);
    chk({tag, "_viol_cnt"},  32'(viol_cnt),  32'd0);
    chk({tag, "_log_valid"}, 32'(log_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; viol = 6'h3F; pc = 16'h0000; log_clr = 1'b0;

    // Reset with every violation flag set.
    step(1'b1, 6'h3F, 16'h1234, 1'b0);
    chk_zero("rst1");
    step(1'b1, 6'h3F, 16'h1234, 1'b0);
    chk_zero("rst2");
    step(1'b0, 6'h00, 16'h1234, 1'b0);
    step(1'b0, 6'h00, 16'h1234, 1'b0);
    chk_zero("rel");

    // Single event: 16-cycle pulse, log captured.
    step(1'b0, 6'b000010, 16'hA010, 1'b0);
    chk("ev_sys_rst",  32'(sys_rst),  32'd1);
    chk("ev_cause",    32'(cause),    32'h02);
    chk("ev_cause_pc", 32'(cause_pc), 32'hA010);
    chk("ev_viol_cnt", 32'(viol_cnt), 32'd1);
    chk("h1_sys_rst",  32'(sys_rst_h1), 32'd1);
    chk("h1_log",      {sys_rst_h1, log_valid_h1, viol_cnt_h1, cause_h1, cause_pc_h1[7:0]}, {1'b1, 1'b1, 8'd1, 6'h02, 8'h10});
    for (int i = 1; i < H; i++) begin
      step(1'b0, 6'h00, 16'h2000, 1'b0);
      if (i == 1) chk("h1_end", 32'(sys_rst_h1), 32'd0);
      if (i == H - 1) chk("ev_last_high", 32'(sys_rst), 32'd1);
    end
    step(1'b0, 6'h00, 16'h2000, 1'b0);
    chk("ev_low", 32'(sys_rst), 32'd0);
    step(1'b0, 6'h00, 16'h0000, 1'b0);
    step(1'b0, 6'h00, 16'h0100, 1'b0);
    chk("ev_idle", 32'(sys_rst), 32'd0);

    // Accumulate mid-HOLD, then extend by holding a flag on the last cycle.
    step(1'b1, 6'h00, 16'h0000, 1'b0);
    step(1'b0, 6'h00, 16'h0000, 1'b0);
    step(1'b0, 6'h01, 16'hB000, 1'b0);
    for (int j = 1; j <= H; j++) begin
      step(1'b0, (j == 5) ? 6'h10 : ((j == H) ? 6'h04 : 6'h00), 16'hB100, 1'b0);
      if (j == 5) begin
        chk("acc_cause", 32'(cause),    32'h11);
        chk("acc_cnt",   32'(viol_cnt), 32'd1);
      end
    end
    chk("ext_high", 32'(sys_rst), 32'd1);
    for (int j = H + 1; j < 2 * H; j++) step(1'b0, 6'h00, 16'hB200, 1'b0);
    chk("ext_last_high", 32'(sys_rst), 32'd1);
    chk("ext_cnt",       32'(viol_cnt), 32'd1);
    step(1'b0, 6'h00, 16'hB200, 1'b0);
    chk("ext_low", 32'(sys_rst), 32'd0);

    // Re-violation in WAIT_HANDLER, coinciding with the handler PC.
    step(1'b0, 6'h08, 16'h0000, 1'b0);
    chk("rv_sys_rst",  32'(sys_rst),  32'd1);
    chk("rv_cnt",      32'(viol_cnt), 32'd2);
    chk("rv_cause",    32'(cause),    32'h08);
    chk("rv_cause_pc", 32'(cause_pc), 32'h0000);
    for (int j = 1; j <= H; j++) step(1'b0, 6'h00, 16'h0000, 1'b0);
    chk("rv_low", 32'(sys_rst), 32'd0);

    // Counter saturation over 300 events.
    step(1'b1, 6'h00, 16'h0000, 1'b0);
    for (int e = 0; e < 300; e++) begin
      step(1'b0, 6'h01, 16'(e), 1'b0);
      for (int j = 1; j <= H; j++) step(1'b0, 6'h00, 16'h0000, 1'b0);
    end
    chk("sat_cnt",   32'(viol_cnt),  32'd255);
    chk("sat_valid", 32'(log_valid), 32'd1);

    // log_clr alone, outside HOLD.
    step(1'b0, 6'h00, 16'h0040, 1'b1);
    chk("clr_cnt",     32'(viol_cnt),  32'd0);
    chk("clr_valid",   32'(log_valid), 32'd0);
    chk("clr_sys_rst", 32'(sys_rst),   32'd0);
    chk("clr_cause",   32'(cause),     32'd0);

    // log_clr during HOLD does not touch the pulse.
    step(1'b0, 6'h02, 16'h0044, 1'b0);
    for (int j = 1; j <= 3; j++) step(1'b0, 6'h00, 16'h0044, 1'b0);
    step(1'b0, 6'h00, 16'h0044, 1'b1);
    chk("hclr_sys_rst", 32'(sys_rst),  32'd1);
    chk("hclr_cnt",     32'(viol_cnt), 32'd0);
    chk("hclr_cause",   32'(cause),    32'd0);
    for (int j = 5; j <= H; j++) step(1'b0, 6'h00, 16'h0044, 1'b0);
    chk("hclr_low", 32'(sys_rst), 32'd0);

    // log_clr together with an event: the capture wins.
    step(1'b0, 6'h20, 16'h5555, 1'b1);
    chk("cev_cnt",     32'(viol_cnt), 32'd1);
    chk("cev_cause",   32'(cause),    32'h20);
    chk("cev_pc",      32'(cause_pc), 32'h5555);
    chk("cev_sys_rst", 32'(sys_rst),  32'd1);

    // Reset in the middle of HOLD.
    for (int j = 1; j <= 4; j++) step(1'b0, 6'h00, 16'h6000, 1'b0);
    chk("mid_pre", 32'(sys_rst), 32'd1);
    step(1'b1, 6'h00, 16'h6000, 1'b0);
    chk_zero("mid_rst");
    step(1'b0, 6'h00, 16'h6000, 1'b0);
    chk_zero("mid_rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
